pe_horner: RTL and testbench

Next-generation systolic processing element. It keeps the GEMM multiply-accumulate datapath and adds a self-sequenced unary mode: a parametrised Horner polynomial evaluator covering div, exp and log approximations. The evaluator has a local coefficient buffer, a load/evaluate FSM and a valid/done handshake. It sits in the PE array; the `wc`/`x` forwarding chains and `o` partial-sum chain are unchanged so it drops into existing arrays.

---
 rtl/pe_pkg.sv | 39 +++
 rtl/pe_coef_buf.sv | 30 +++
 rtl/pe_horner.sv | 186 ++++++++++++++++++
 tb/tb_pe_horner.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the pe_horner processing element:
// operating modes, sequencer states, Q-format width and saturation limits.
package pe_pkg;

    typedef enum logic [1:0] {
        MODE_GEMM = 2'b00,
        MODE_DIV  = 2'b01,
        MODE_EXP  = 2'b10,
        MODE_LOG  = 2'b11
    } pe_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EVAL,
        ST_DONE
    } pe_state_e;

    localparam int PE_DEF_INT_BW = 5;
    localparam int PE_DEF_FRA_BW = 5;

    // Operand width: sign bit plus integer and fraction bits.
    function automatic int pe_w(input int int_bw, input int fra_bw);
        return int_bw + fra_bw + 1;
    endfunction

    function automatic int pe_sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int pe_sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int PE_DEF_W       = PE_DEF_INT_BW + PE_DEF_FRA_BW + 1;
    localparam int PE_DEF_SAT_MAX = (1 << (PE_DEF_W - 1)) - 1;
    localparam int PE_DEF_SAT_MIN = -(1 << (PE_DEF_W - 1));

endpackage

// File: rtl/pe_coef_buf.sv
// Polynomial coefficient register file for pe_horner: TERMS x W entries,
// one synchronous write port, one combinational read port, async clear on rst_n.
module pe_coef_buf
#(
    parameter  int TERMS = 6,
    parameter  int W     = 11,
    localparam int AW    = $clog2(TERMS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic signed [W-1:0] wdata_i,
    input  logic [AW-1:0]       raddr_i,
    output logic signed [W-1:0] rdata_o
);

    logic signed [W-1:0] mem_q [TERMS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TERMS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pe_horner.sv
// Systolic PE: GEMM multiply-accumulate plus a self-sequenced Horner polynomial
// evaluator. Define PE_HORNER_SAT_EN for saturating renormalisation and the sat_o flag.
module pe_horner
    import pe_pkg::*;
#(
    parameter int INT_BW = PE_DEF_INT_BW,
    parameter int FRA_BW = PE_DEF_FRA_BW,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int TERMS  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              start_i,
    input  logic              reuse_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic              wc_vld_i,
    input  logic [ACC_BW-1:0] o_i,
    output logic [MUL_BW-1:0] x_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic [ACC_BW-1:0] o_o,
    output logic              busy_o,
    output logic              done_o
`ifdef PE_HORNER_SAT_EN
    ,
    output logic              sat_o
`endif
);

    localparam int W  = pe_w(INT_BW, FRA_BW);
    localparam int AW = $clog2(TERMS);

    pe_state_e                state_q, state_d;
    logic [AW-1:0]            idx_q, idx_d;
    logic signed [W-1:0]      acc_q, acc_d;
    logic signed [W-1:0]      xarg_q, xarg_d;
    logic [ACC_BW-1:0]        o_q, o_d;
    logic [MUL_BW-1:0]        x_q, wc_q;

    logic signed [W-1:0]      xq, wq, xin, win, coef_rd;
    logic signed [ACC_BW-1:0] o_in, gemm_sum, sum;
    logic                     buf_we;
    logic [AW-1:0]            rd_addr;

`ifdef PE_HORNER_SAT_EN
    localparam logic signed [ACC_BW-1:0] LIM_HI = ACC_BW'(pe_sat_max(W));
    localparam logic signed [ACC_BW-1:0] LIM_LO = ACC_BW'(pe_sat_min(W));
    logic sat_q, sat_d;

    function automatic logic clamps(input logic signed [ACC_BW-1:0] v);
        logic signed [ACC_BW-1:0] s;
        s = v >>> FRA_BW;
        return (s > LIM_HI) || (s < LIM_LO);
    endfunction
`endif

    // Drop the product's extra fraction bits and bring the result back to W bits.
    function automatic logic signed [W-1:0] renorm(input logic signed [ACC_BW-1:0] v);
        logic signed [ACC_BW-1:0] s;
        s = v >>> FRA_BW;
`ifdef PE_HORNER_SAT_EN
        if (s > LIM_HI) return W'(pe_sat_max(W));
        if (s < LIM_LO) return W'(pe_sat_min(W));
`endif
        return s[W-1:0];
    endfunction

    assign xq   = x_q[MUL_BW-1 -: W];
    assign wq   = wc_q[MUL_BW-1 -: W];
    assign xin  = x_i[MUL_BW-1 -: W];
    assign win  = wc_i[MUL_BW-1 -: W];
    assign o_in = o_i;

    assign gemm_sum = ACC_BW'(wq) * ACC_BW'(xq) + o_in;
    assign sum      = ACC_BW'(acc_q) * ACC_BW'(xarg_q) + (ACC_BW'(coef_rd) <<< FRA_BW);

    pe_coef_buf #(
        .TERMS (TERMS),
        .W     (W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (buf_we),
        .waddr_i (AW'(TERMS - 1) - idx_q),
        .wdata_i (win),
        .raddr_i (rd_addr),
        .rdata_o (coef_rd)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        xarg_d  = xarg_q;
        o_d     = o_q;
        buf_we  = 1'b0;
        rd_addr = idx_q;
`ifdef PE_HORNER_SAT_EN
        sat_d   = sat_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                rd_addr = AW'(TERMS - 1);
                if (pe_mode_e'(mode_i) == MODE_GEMM) begin
                    o_d = gemm_sum;
                end else if (start_i) begin
                    xarg_d = xin;
`ifdef PE_HORNER_SAT_EN
                    sat_d  = 1'b0;
`endif
                    if (reuse_i) begin
                        state_d = ST_EVAL;
                        acc_d   = coef_rd;
                        idx_d   = AW'(TERMS - 2);
                    end else begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                    end
                end
            end
            ST_LOAD: begin
                if (wc_vld_i) begin
                    buf_we = 1'b1;
                    if (idx_q == '0) acc_d = win;
                    if (idx_q == AW'(TERMS - 1)) begin
                        state_d = ST_EVAL;
                        idx_d   = AW'(TERMS - 2);
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            ST_EVAL: begin
                acc_d = renorm(sum);
`ifdef PE_HORNER_SAT_EN
                sat_d = sat_q | clamps(sum);
`endif
                if (idx_q == '0) begin
                    o_d     = sum;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - AW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            xarg_q  <= '0;
            o_q     <= '0;
            x_q     <= '0;
            wc_q    <= '0;
`ifdef PE_HORNER_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            xarg_q  <= xarg_d;
            o_q     <= o_d;
            x_q     <= x_i;
            wc_q    <= wc_i;
`ifdef PE_HORNER_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign x_o    = x_q;
    assign wc_o   = wc_q;
    assign o_o    = o_q;
    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
`ifdef PE_HORNER_SAT_EN
    assign sat_o  = sat_q;
`endif

endmodule

// File: tb/tb_pe_horner.sv
// Self-checking bench for pe_horner: GEMM forwarding/MAC and Horner evaluation
// against a plain-arithmetic polynomial model (saturating when PE_HORNER_SAT_EN).
module tb_pe_horner;

    localparam int INT_BW = 5;
    localparam int FRA_BW = 5;
    localparam int MUL_BW = 16;
    localparam int ACC_BW = 32;
    localparam int TERMS  = 6;
    localparam int W      = INT_BW + FRA_BW + 1;
    localparam int QMAX   = (1 << (W - 1)) - 1;
    localparam int QMIN   = -(1 << (W - 1));
    localparam int LOWB   = MUL_BW - W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode_i;
    logic              start_i, reuse_i, wc_vld_i;
    logic [MUL_BW-1:0] x_i, wc_i, x_o, wc_o;
    logic [ACC_BW-1:0] o_i, o_o;
    logic              busy_o, done_o;
`ifdef PE_HORNER_SAT_EN
    logic              sat_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int buf_m [TERMS];

    pe_horner #(
        .INT_BW (INT_BW),
        .FRA_BW (FRA_BW),
        .MUL_BW (MUL_BW),
        .ACC_BW (ACC_BW),
        .TERMS  (TERMS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode_i   (mode_i),
        .start_i  (start_i),
        .reuse_i  (reuse_i),
        .x_i      (x_i),
        .wc_i     (wc_i),
        .wc_vld_i (wc_vld_i),
        .o_i      (o_i),
        .x_o      (x_o),
        .wc_o     (wc_o),
        .o_o      (o_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
`ifdef PE_HORNER_SAT_EN
        ,
        .sat_o    (sat_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Q value -> port word with random don't-care low bits.
    function automatic logic [MUL_BW-1:0] to_in(input int q);
        int v;
        v = ((q & ((1 << W) - 1)) << LOWB) | int'($urandom_range(0, (1 << LOWB) - 1));
        return MUL_BW'(v);
    endfunction

    function automatic int top_q(input logic [MUL_BW-1:0] v);
        int t;
        t = int'(v) >> LOWB;
        if (t > QMAX) t -= (1 << W);
        return t;
    endfunction

    function automatic longint renorm_m(input longint s, inout bit sat);
        longint q;
        q = s >>> FRA_BW;
`ifdef PE_HORNER_SAT_EN
        if (q > QMAX) begin q = QMAX; sat = 1'b1; end
        else if (q < QMIN) begin q = QMIN; sat = 1'b1; end
`else
        q = q & ((1 << W) - 1);
        if (q > QMAX) q -= (1 << W);
`endif
        return q;
    endfunction

    // p(x) = sum c[k] x^k, evaluated highest order first; s is the last unrenormalised sum.
    function automatic void horner(input int xq, input int c[TERMS], output longint s, output bit sat);
        longint acc;
        acc = c[TERMS-1];
        sat = 1'b0;
        s   = 0;
        for (int k = TERMS - 2; k >= 0; k--) begin
            s   = acc * xq + longint'(c[k]) * (1 << FRA_BW);
            acc = renorm_m(s, sat);
        end
    endfunction

    function automatic int rnd_q();
        return int'($urandom_range(0, (1 << W) - 1)) + QMIN;
    endfunction

    task automatic do_unary(input string tag, input int xq, input int cq[TERMS],
                            input bit reuse, input int gap, input bit noise);
        longint      s;
        bit          sat;
        int          c [TERMS];
        int          edges;
        int          exp_lat;
        logic [31:0] e;
        if (reuse) c = buf_m; else c = cq;
        horner(xq, c, s, sat);
        if (!reuse) buf_m = cq;
        exp_lat = reuse ? TERMS - 1 : 2 * TERMS - 1 + TERMS * gap;

        mode_i   = 2'($urandom_range(1, 3));
        x_i      = to_in(xq);
        start_i  = 1'b1;
        reuse_i  = reuse;
        wc_vld_i = 1'b0;
        wc_i     = MUL_BW'($urandom);
        step();
        edges    = 0;
        start_i  = 1'b0;
        reuse_i  = 1'b0;
        mode_i   = 2'b00;
        x_i      = MUL_BW'($urandom);
        check({tag, "_busy_rise"}, busy_o, 1);

        if (!reuse) begin
            for (int i = 0; i < TERMS; i++) begin
                for (int g = 0; g < gap; g++) begin
                    wc_vld_i = 1'b0;
                    wc_i     = MUL_BW'($urandom);
                    step();
                    edges++;
                end
                wc_vld_i = 1'b1;
                wc_i     = to_in(cq[TERMS-1-i]);
                step();
                edges++;
            end
            wc_vld_i = 1'b0;
        end

        while (!done_o && edges < 200) begin
            if (noise) begin
                start_i = 1'($urandom_range(0, 1));
                reuse_i = 1'($urandom_range(0, 1));
                mode_i  = 2'($urandom_range(0, 3));
            end
            step();
            edges++;
        end
        start_i = 1'b0;
        reuse_i = 1'b0;
        mode_i  = 2'b00;

        e = 32'(s);
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_o"}, o_o, e);
        check({tag, "_busy_done"}, busy_o, 1);
`ifdef PE_HORNER_SAT_EN
        check({tag, "_sat"}, sat_o, sat);
`endif
        step();
        check({tag, "_done_fall"}, done_o, 0);
        check({tag, "_busy_fall"}, busy_o, 0);
    endtask

    initial begin
        int          ones [TERMS];
        int          maxc [TERMS];
        int          zc   [TERMS];
        int          rc   [TERMS];
        int          pw, px;
        logic [31:0] e;

        for (int i = 0; i < TERMS; i++) begin
            ones[i]  = 1 << FRA_BW;
            maxc[i]  = QMAX;
            zc[i]    = 0;
            buf_m[i] = 0;
        end

        rst_n = 1'b0; mode_i = 2'b00; start_i = 1'b0; reuse_i = 1'b0;
        x_i = '0; wc_i = '0; wc_vld_i = 1'b0; o_i = '0;
        step();
        step();
        check("rst_x_o", x_o, 0);
        check("rst_wc_o", wc_o, 0);
        check("rst_o_o", o_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
`ifdef PE_HORNER_SAT_EN
        check("rst_sat", sat_o, 0);
`endif
        rst_n = 1'b1;

        // GEMM directed: 2.0 * 3.0 + 100
        wc_i = 16'd2048; x_i = 16'd3072; o_i = 32'd100;
        step();
        check("gemm_first_edge", o_o, 100);
        check("gemm_wc_fwd", wc_o, 2048);
        step();
        check("gemm_2x3", o_o, 6244);
        pw = 2048; px = 3072;

        for (int i = 0; i < 16; i++) begin
            wc_i = MUL_BW'($urandom);
            x_i  = MUL_BW'($urandom);
            o_i  = $urandom;
            step();
            e = 32'(top_q(MUL_BW'(pw)) * top_q(MUL_BW'(px)) + int'(o_i));
            check("gemm_rand_o", o_o, e);
            check("gemm_rand_x_fwd", x_o, x_i);
            check("gemm_rand_wc_fwd", wc_o, wc_i);
            pw = int'(wc_i); px = int'(x_i);
        end

        do_unary("load_ones", 1 << FRA_BW, ones, 1'b0, 0, 1'b0);
        check("load_ones_val", o_o, 6144);
        do_unary("reuse_ones", 1 << FRA_BW, zc, 1'b1, 0, 1'b0);
        check("reuse_ones_val", o_o, 6144);
        do_unary("sat_max", QMAX, maxc, 1'b0, 0, 1'b0);

        for (int i = 0; i < TERMS; i++) rc[i] = rnd_q() / 4;
        do_unary("gap3_noise", rnd_q() / 8, rc, 1'b0, 3, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < TERMS; i++) rc[i] = (t < 3) ? rnd_q() / 16 : rnd_q();
            do_unary("rand", (t < 3) ? rnd_q() / 16 : rnd_q(), rc, t == 4, t % 3, t[0]);
        end

        // Reset in the middle of a reuse evaluation
        mode_i = 2'b10; x_i = to_in(rnd_q()); start_i = 1'b1; reuse_i = 1'b1;
        step();
        start_i = 1'b0; reuse_i = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_o_o", o_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_x_o", x_o, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < TERMS; i++) buf_m[i] = 0;
        do_unary("reuse_after_rst", rnd_q(), zc, 1'b1, 0, 1'b0);
        check("reuse_after_rst_zero", o_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
